// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in, parallel-out deserializer.
package sipo_pkg;

    typedef enum logic [0:0] {EMPTY, FULL} out_state_t;

    // Constant ceil(log2(value)); sizes the bit counter as clog2(WIDTH+1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = unsigned'(i + 1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, parallel output handshake and overrun status bundle.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             sin_data;
    logic             sin_valid;
    logic             sin_start;
    logic [WIDTH-1:0] pout_data;
    logic             pout_valid;
    logic             pout_ready;
    logic             overrun;
    logic             ovr_clr;

    modport master (
        output sin_data, sin_valid, sin_start, pout_ready, ovr_clr,
        input  pout_data, pout_valid, overrun
    );

    modport slave (
        input  sin_data, sin_valid, sin_start, pout_ready, ovr_clr,
        output pout_data, pout_valid, overrun
    );

endinterface

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; word is the next-state value so the caller
// can capture the completed word on the same edge that accepts its last bit.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_data,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    localparam int unsigned CNT_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d, shifted;

    always_comb begin
        shifted   = sr_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;

        // A start bit shifts into an empty register, discarding the partial word.
        if (MSB_FIRST) begin
            shifted = sin_start ? {{(WIDTH-1){1'b0}}, sin_data} : {sr_q[WIDTH-2:0], sin_data};
        end else begin
            shifted = sin_start ? {sin_data, {(WIDTH-1){1'b0}}} : {sin_data, sr_q[WIDTH-1:1]};
        end

        if (sin_valid) begin
            sr_d = shifted;
            if (sin_start) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (sin_start) begin
            cnt_d = '0;
            sr_d  = '0;
        end
    end

    assign word = sr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: one-word holding register with valid/ready
// handshake and a sticky overrun flag for words dropped while the holder is full.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    sipo_deserializer_if.slave  bus
);

    logic [WIDTH-1:0] word;
    logic             word_done;
    out_state_t       state_q;
    logic [WIDTH-1:0] data_q;
    logic             ovr_q;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin_data  (bus.sin_data),
        .sin_valid (bus.sin_valid),
        .sin_start (bus.sin_start),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (word_done) begin
                        state_q <= FULL;
                        data_q  <= word;
                    end
                end
                FULL: begin
                    // A read coinciding with completion swaps words with no bubble.
                    if (word_done) begin
                        if (bus.pout_ready) begin
                            data_q <= word;
                        end
                    end else if (bus.pout_ready) begin
                        state_q <= EMPTY;
                    end
                end
            endcase

            // Setting wins over a simultaneous clear.
            if (word_done && (state_q == FULL) && !bus.pout_ready) begin
                ovr_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign bus.pout_data  = data_q;
    assign bus.pout_valid = (state_q == FULL);
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: a vector table plus reset and LSB-first sequences.
module tb_sipo_deserializer;

    localparam int unsigned W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(W)) bus ();
    sipo_deserializer_if #(.WIDTH(W)) bus_lsb ();

    sipo_deserializer #(
        .WIDTH     (W),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sipo_deserializer #(
        .WIDTH     (W),
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lsb)
    );

    typedef struct {
        logic       d;
        logic       v;
        logic       s;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [3:0] edata;
        logic       eo;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic d, input logic v, input logic s, input logic rdy,
                       input logic clr, input logic ev, input logic [3:0] edata,
                       input logic eo);
        vec_t t;
        t.d = d; t.v = v; t.s = s; t.rdy = rdy; t.clr = clr;
        t.ev = ev; t.edata = edata; t.eo = eo;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got valid,data,ovr=%b want %b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the MSB-first DUT and step to just after the edge.
    task automatic drive(input logic d, input logic v, input logic s, input logic rdy,
                         input logic clr);
        bus.sin_data   = d;
        bus.sin_valid  = v;
        bus.sin_start  = s;
        bus.pout_ready = rdy;
        bus.ovr_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] obs();
        return {bus.pout_valid, bus.pout_data, bus.overrun};
    endfunction

    function automatic logic [5:0] obs_lsb();
        return {bus_lsb.pout_valid, bus_lsb.pout_data, bus_lsb.overrun};
    endfunction

    initial begin
        bus.sin_data = 0; bus.sin_valid = 0; bus.sin_start = 0;
        bus.pout_ready = 0; bus.ovr_clr = 0;
        bus_lsb.sin_data = 0; bus_lsb.sin_valid = 0; bus_lsb.sin_start = 0;
        bus_lsb.pout_ready = 0; bus_lsb.ovr_clr = 0;

        // 1: 0101, ready high
        add(0,1,0,1,0, 0,4'h0,0); add(1,1,0,1,0, 0,4'h0,0);
        add(0,1,0,1,0, 0,4'h0,0); add(1,1,0,1,0, 1,4'h5,0);
        add(0,0,0,1,0, 0,4'h5,0);
        // 2: 0110 then 1010 continuous
        add(0,1,0,1,0, 0,4'h5,0); add(1,1,0,1,0, 0,4'h5,0);
        add(1,1,0,1,0, 0,4'h5,0); add(0,1,0,1,0, 1,4'h6,0);
        add(1,1,0,1,0, 0,4'h6,0); add(0,1,0,1,0, 0,4'h6,0);
        add(1,1,0,1,0, 0,4'h6,0); add(0,1,0,1,0, 1,4'hA,0);
        add(0,0,0,1,0, 0,4'hA,0);
        // 3: ready low, 1111 then 0000 -> overrun; clear; drain
        add(1,1,0,0,0, 0,4'hA,0); add(1,1,0,0,0, 0,4'hA,0);
        add(1,1,0,0,0, 0,4'hA,0); add(1,1,0,0,0, 1,4'hF,0);
        add(0,1,0,0,0, 1,4'hF,0); add(0,1,0,0,0, 1,4'hF,0);
        add(0,1,0,0,0, 1,4'hF,0); add(0,1,0,0,0, 1,4'hF,1);
        add(0,0,0,0,1, 1,4'hF,0); add(0,0,0,1,0, 0,4'hF,0);
        // 4: 1,1, start with 0, then 0,1,1 -> 0011
        add(1,1,0,1,0, 0,4'hF,0); add(1,1,0,1,0, 0,4'hF,0);
        add(0,1,1,1,0, 0,4'hF,0); add(0,1,0,1,0, 0,4'hF,0);
        add(1,1,0,1,0, 0,4'hF,0); add(1,1,0,1,0, 1,4'h3,0);
        add(0,0,0,1,0, 0,4'h3,0);
        // 5: a bit every third cycle, 1001
        add(1,1,0,1,0, 0,4'h3,0); add(0,0,0,1,0, 0,4'h3,0); add(0,0,0,1,0, 0,4'h3,0);
        add(0,1,0,1,0, 0,4'h3,0); add(0,0,0,1,0, 0,4'h3,0); add(0,0,0,1,0, 0,4'h3,0);
        add(0,1,0,1,0, 0,4'h3,0); add(0,0,0,1,0, 0,4'h3,0); add(0,0,0,1,0, 0,4'h3,0);
        add(1,1,0,1,0, 1,4'h9,0); add(0,0,0,1,0, 0,4'h9,0);
        // start without valid zeroes the counter: 1,1, start, then 1010
        add(1,1,0,1,0, 0,4'h9,0); add(1,1,0,1,0, 0,4'h9,0);
        add(0,0,1,1,0, 0,4'h9,0); add(1,1,0,1,0, 0,4'h9,0);
        add(0,1,0,1,0, 0,4'h9,0); add(1,1,0,1,0, 0,4'h9,0);
        add(0,1,0,1,0, 1,4'hA,0); add(0,0,0,1,0, 0,4'hA,0);
        // back-to-back: FULL with ready on the completing edge swaps in the new word
        add(1,1,0,0,0, 0,4'hA,0); add(1,1,0,0,0, 0,4'hA,0);
        add(0,1,0,0,0, 0,4'hA,0); add(0,1,0,0,0, 1,4'hC,0);
        add(0,1,0,0,0, 1,4'hC,0); add(0,1,0,0,0, 1,4'hC,0);
        add(1,1,0,0,0, 1,4'hC,0); add(1,1,0,1,0, 1,4'h3,0);
        add(0,0,0,1,0, 0,4'h3,0);
        // overrun set wins over a same-cycle clear
        add(1,1,0,0,0, 0,4'h3,0); add(0,1,0,0,0, 0,4'h3,0);
        add(1,1,0,0,0, 0,4'h3,0); add(0,1,0,0,0, 1,4'hA,0);
        add(0,1,0,0,0, 1,4'hA,0); add(1,1,0,0,0, 1,4'hA,0);
        add(0,1,0,0,0, 1,4'hA,0); add(1,1,0,0,1, 1,4'hA,1);
        add(0,0,0,1,1, 0,4'hA,0);

        #1;
        check("reset_state", obs(), 6'b0_0000_0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].d, vecs[i].v, vecs[i].s, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d", i), obs(), {vecs[i].ev, vecs[i].edata, vecs[i].eo});
        end

        // 6: fill holder, overflow, leave a partial word, then reset between edges
        for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0);
        check("pre_reset_hold", obs(), 6'b1_1111_1);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs(), 6'b0_0000_0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        check("post_reset_partial", obs(), 6'b0_0000_0);
        drive(0, 1, 0, 1, 0);
        check("post_reset_word", obs(), 6'b1_1010_0);

        // LSB-first instance: 0,1,0,1 -> 1010
        bus.sin_valid = 0;
        bus_lsb.pout_ready = 1;
        bus_lsb.sin_valid  = 1;
        for (int i = 0; i < 4; i++) begin
            bus_lsb.sin_data = (i % 2 == 1);
            @(posedge clk);
            #1;
            if (i == 2) check("lsb_partial", obs_lsb(), 6'b0_0000_0);
        end
        check("lsb_word", obs_lsb(), 6'b1_1010_0);
        bus_lsb.sin_valid = 0;
        @(posedge clk);
        #1;
        check("lsb_drain", obs_lsb(), 6'b0_1010_0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
